// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (800x600@72 and 640x480@60) and the raw sync bundle
// carried down the pixel-latency delay line; also used by the sync-tracking display controller.
package vga_timing_pkg;

  localparam int unsigned COL_W = 11;
  localparam int unsigned ROW_W = 10;
  localparam int unsigned MAX_PIX_LATENCY = 8;

  function automatic int unsigned timing_total(input int unsigned vis, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  // 800x600@72, 50 MHz pixel clock
  localparam int unsigned SVGA_H_VISIBLE = 800;
  localparam int unsigned SVGA_H_FRONT   = 56;
  localparam int unsigned SVGA_H_SYNC    = 120;
  localparam int unsigned SVGA_H_BACK    = 64;
  localparam int unsigned SVGA_V_VISIBLE = 600;
  localparam int unsigned SVGA_V_FRONT   = 37;
  localparam int unsigned SVGA_V_SYNC    = 6;
  localparam int unsigned SVGA_V_BACK    = 23;
  localparam int unsigned SVGA_H_TOTAL   = timing_total(SVGA_H_VISIBLE, SVGA_H_FRONT, SVGA_H_SYNC, SVGA_H_BACK);
  localparam int unsigned SVGA_V_TOTAL   = timing_total(SVGA_V_VISIBLE, SVGA_V_FRONT, SVGA_V_SYNC, SVGA_V_BACK);
  localparam int unsigned SVGA_HS_START  = SVGA_H_VISIBLE + SVGA_H_FRONT;
  localparam int unsigned SVGA_HS_END    = SVGA_HS_START + SVGA_H_SYNC;
  localparam int unsigned SVGA_VS_START  = SVGA_V_VISIBLE + SVGA_V_FRONT;
  localparam int unsigned SVGA_VS_END    = SVGA_VS_START + SVGA_V_SYNC;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_H_TOTAL   = timing_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  localparam int unsigned VGA_V_TOTAL   = timing_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);
  localparam int unsigned VGA_HS_START  = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int unsigned VGA_HS_END    = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START  = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int unsigned VGA_VS_END    = VGA_VS_START + VGA_V_SYNC;

  // Raw, active-high request-side syncs; polarity is applied only at the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic req;
  } sync_bits_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset; DEPTH=0 is a pure wire.
module vga_delay_line #(
  parameter int unsigned       WIDTH       = 3,
  parameter int unsigned       DEPTH       = 2,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= RESET_VALUE;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_generator.sv
// Transmit-side VGA timing source: free-running col/row counters, pixel request decode,
// syncs delayed to match the source read latency, and blanked RGB on a common output register.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = SVGA_H_VISIBLE,
  parameter int unsigned H_FRONT     = SVGA_H_FRONT,
  parameter int unsigned H_SYNC      = SVGA_H_SYNC,
  parameter int unsigned H_BACK      = SVGA_H_BACK,
  parameter int unsigned V_VISIBLE   = SVGA_V_VISIBLE,
  parameter int unsigned V_FRONT     = SVGA_V_FRONT,
  parameter int unsigned V_SYNC      = SVGA_V_SYNC,
  parameter int unsigned V_BACK      = SVGA_V_BACK,
  parameter logic        HS_POL      = 1'b1,
  parameter logic        VS_POL      = 1'b1,
  parameter int unsigned PIX_LATENCY = 2,
  parameter int unsigned RGB_W       = 12
) (
  input  logic             clock,
  input  logic             reset,
  output logic             pix_req,
  output logic [10:0]      pix_col,
  output logic [9:0]       pix_row,
  output logic             frame_start,
  input  logic [RGB_W-1:0] pix_rgb,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             visible
);

  localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_VISIBLE == 0 || V_VISIBLE == 0 || H_SYNC == 0 || V_SYNC == 0 || RGB_W == 0 ||
      H_TOTAL > (1 << COL_W) || V_TOTAL > (1 << ROW_W) || PIX_LATENCY > MAX_PIX_LATENCY) begin : g_param_check
    $error("vga_sync_generator: timing parameters out of range");
  end

  // Bounds are one bit wider than the counters so an end value equal to 2**W stays exact.
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);
  localparam logic [COL_W:0]   COL_VIS  = (COL_W+1)'(H_VISIBLE);
  localparam logic [COL_W:0]   HS_START = (COL_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [COL_W:0]   HS_END   = (COL_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [ROW_W:0]   ROW_VIS  = (ROW_W+1)'(V_VISIBLE);
  localparam logic [ROW_W:0]   VS_START = (ROW_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [ROW_W:0]   VS_END   = (ROW_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [COL_W:0]   w_col_x;
  logic [ROW_W:0]   w_row_x;
  sync_bits_t       w_raw;
  sync_bits_t       w_dly;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_col == COL_LAST) begin
      r_col <= '0;
      r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
    end else begin
      r_col <= r_col + 1'b1;
    end
  end

  assign w_col_x = {1'b0, r_col};
  assign w_row_x = {1'b0, r_row};

  // Counters read 0/0 while reset is held, so the decode is gated to keep requests and syncs idle.
  always_comb begin
    w_raw = '0;
    if (!reset) begin
      w_raw.hs  = (w_col_x >= HS_START) && (w_col_x < HS_END);
      w_raw.vs  = (w_row_x >= VS_START) && (w_row_x < VS_END);
      w_raw.req = (w_col_x < COL_VIS) && (w_row_x < ROW_VIS);
    end else begin
      w_raw = '0;
    end
  end

  assign pix_req     = w_raw.req;
  assign pix_col     = r_col;
  assign pix_row     = r_row;
  assign frame_start = ~reset & (r_col == '0) & (r_row == '0);

  vga_delay_line #(
    .WIDTH       ($bits(sync_bits_t)),
    .DEPTH       (PIX_LATENCY),
    .RESET_VALUE ('0)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .i_d   (w_raw),
    .o_q   (w_dly)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      vga_rgb <= '0;
      visible <= 1'b0;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
    end else begin
      vga_rgb <= w_dly.req ? pix_rgb : '0;
      visible <= w_dly.req;
      hsync   <= w_dly.hs ^ ~HS_POL;
      vsync   <= w_dly.vs ^ ~VS_POL;
    end
  end

endmodule
